wb_uart_fifo: RTL and testbench

//  Wishbone classic slave UART for the picorv32 Wishbone SoC; replaces the fixed-rate uart_rx/uart_tx pins path.

---
 rtl/wb_uart_fifo_pkg.sv | 27 ++
 rtl/wb_uart_fifo_fifo.sv | 41 ++++
 rtl/wb_uart_fifo.sv | 174 +++++++++++++++++
 tb/tb_wb_uart_fifo.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_uart_fifo_pkg.sv
// wb_uart_fifo_pkg: register map, status/control bit indices, FSM encodings and divisor clamp
package wb_uart_fifo_pkg;
    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_STAT = 2'd1;
    localparam logic [1:0] REG_DIV  = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;
    localparam int STAT_RXNE   = 0;
    localparam int STAT_TXFULL = 1;
    localparam int STAT_TXIDLE = 2;
    localparam int STAT_OVR    = 3;
    localparam int STAT_FERR   = 4;
    localparam int CTRL_RXIE   = 0;
    localparam int CTRL_TXIE   = 1;
    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;
    localparam logic [2:0] RX_IDLE  = 3'd0;
    localparam logic [2:0] RX_START = 3'd1;
    localparam logic [2:0] RX_DATA  = 3'd2;
    localparam logic [2:0] RX_STOP  = 3'd3;
    localparam logic [2:0] RX_WAIT  = 3'd4;
    localparam logic [31:0] MIN_DIV = 32'd4;
    function automatic logic [31:0] clamp_div(input logic [31:0] v);
        return (v < MIN_DIV) ? MIN_DIV : v;
    endfunction
endpackage

// File: rtl/wb_uart_fifo_fifo.sv
// uart_sync_fifo: single-clock FIFO with combinational head output; push+pop on full both take effect
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign empty   = count == '0;
    assign full    = count == (AW+1)'(DEPTH);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];
    // storage write; contents need no reset since count gates visibility
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end
    // pointers wrap modulo DEPTH, count tracks occupancy
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/wb_uart_fifo.sv
// wb_uart_fifo: Wishbone classic UART with programmable divisor, TX/RX FIFOs, sticky errors and level irq
module wb_uart_fifo
    import wb_uart_fifo_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 10_000_000,
    parameter int BAUD_RESET  = 9600,
    parameter int DIV_WIDTH   = 16,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq_o
);
    localparam logic [DIV_WIDTH-1:0] DIV_RST = DIV_WIDTH'(CLK_FREQ_HZ / BAUD_RESET);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    logic [1:0] rsel;
    logic req, wr, rd;
    logic [31:0] rdata;
    logic [DIV_WIDTH-1:0] div;
    logic [1:0] ctrl;
    logic overrun, frame_err;
    logic tx_full, tx_empty, tx_pop, tx_end, tx_idle;
    logic [7:0] tx_dout, tx_shift;
    logic [1:0] tx_state;
    logic [2:0] tx_bit;
    logic [DIV_WIDTH-1:0] tx_cnt, tx_div;
    logic rx_full, rx_empty, rx_push, rx_end, rx_mid, rx_stop_ok, rx_ovr_set, rx_ferr_set;
    logic rx_meta, rx_s;
    logic [7:0] rx_dout, rx_shift;
    logic [2:0] rx_state;
    logic [2:0] rx_bit;
    logic [DIV_WIDTH-1:0] rx_cnt, rx_div;
    logic [CW-1:0] tx_count, rx_count;
    logic unused;
    assign unused = ^{wb_adr_i[1:0], wb_dat_i, wb_sel_i[3:1], tx_count, rx_count};
    assign rsel = wb_adr_i[3:2];
    assign req  = wb_stb_i & wb_cyc_i & ~wb_ack_o;
    assign wr   = req & wb_we_i & wb_sel_i[0];
    assign rd   = req & ~wb_we_i;
    assign tx_idle = tx_empty & (tx_state == TX_IDLE);
    assign tx_end  = tx_cnt == tx_div - 1'b1;
    assign tx_pop  = ~tx_empty & ((tx_state == TX_IDLE) | ((tx_state == TX_STOP) & tx_end));
    assign rx_end  = rx_cnt == rx_div - 1'b1;
    assign rx_mid  = rx_cnt == (rx_div >> 1);
    assign rx_stop_ok  = (rx_state == RX_STOP) & rx_end & rx_s;
    assign rx_push     = rx_stop_ok & ~rx_full;
    assign rx_ovr_set  = rx_stop_ok & rx_full;
    assign rx_ferr_set = (rx_state == RX_STOP) & rx_end & ~rx_s;
    uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clock(clock), .reset(reset), .push(wr & (rsel == REG_DATA)), .pop(tx_pop),
        .din(wb_dat_i[7:0]), .dout(tx_dout), .full(tx_full), .empty(tx_empty), .count(tx_count)
    );
    uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clock(clock), .reset(reset), .push(rx_push), .pop(rd & (rsel == REG_DATA)),
        .din(rx_shift), .dout(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_count)
    );
    // read mux; an empty RX FIFO reads as zero with the valid bit clear
    always_comb begin
        rdata = (rsel == REG_DATA) ? (rx_empty ? 32'd0 : {23'd0, 1'b1, rx_dout}) :
                (rsel == REG_STAT) ? {27'd0, frame_err, overrun, tx_idle, tx_full, ~rx_empty} :
                (rsel == REG_DIV)  ? 32'(div) : {30'd0, ctrl};
    end
    // one-wait-state ack with registered read data
    always_ff @(posedge clock) begin
        if (reset) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= req;
            wb_dat_o <= rd ? rdata : 32'd0;
        end
    end
    // config registers, sticky flags (a new error beats a same-cycle clear) and the irq level
    always_ff @(posedge clock) begin
        if (reset) begin
            div       <= DIV_RST;
            ctrl      <= '0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            irq_o     <= 1'b0;
        end else begin
            if (wr & (rsel == REG_DIV)) div <= DIV_WIDTH'(clamp_div(32'(wb_dat_i[DIV_WIDTH-1:0])));
            if (wr & (rsel == REG_CTRL)) ctrl <= wb_dat_i[1:0];
            overrun   <= rx_ovr_set | (overrun & ~(wr & (rsel == REG_STAT) & wb_dat_i[STAT_OVR]));
            frame_err <= rx_ferr_set | (frame_err & ~(wr & (rsel == REG_STAT) & wb_dat_i[STAT_FERR]));
            irq_o     <= (ctrl[CTRL_RXIE] & (~rx_empty | overrun | frame_err)) | (ctrl[CTRL_TXIE] & tx_empty);
        end
    end
    // transmitter: divisor latched per frame, next byte popped at stop end for gapless frames
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            uart_tx  <= 1'b1;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_div   <= DIV_RST;
        end else begin
            tx_cnt <= (tx_state == TX_IDLE || tx_end) ? '0 : tx_cnt + 1'b1;
            if (tx_pop) begin
                tx_state <= TX_START;
                tx_shift <= tx_dout;
                tx_div   <= div;
                uart_tx  <= 1'b0;
            end else if (tx_end) begin
                case (tx_state)
                    TX_START: begin
                        tx_state <= TX_DATA;
                        tx_bit   <= '0;
                        uart_tx  <= tx_shift[0];
                    end
                    TX_DATA: begin
                        tx_state <= (tx_bit == 3'd7) ? TX_STOP : TX_DATA;
                        tx_bit   <= tx_bit + 1'b1;
                        tx_shift <= tx_shift >> 1;
                        uart_tx  <= (tx_bit == 3'd7) ? 1'b1 : tx_shift[1];
                    end
                    TX_STOP: tx_state <= TX_IDLE;
                    default: tx_state <= TX_IDLE;
                endcase
            end
        end
    end
    // two-flop synchroniser for the asynchronous serial input
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
        end
    end
    // receiver: qualify start at half-bit, then sample each bit centre; bad stop waits for idle line
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_div   <= DIV_RST;
        end else begin
            rx_cnt <= (rx_state == RX_IDLE || rx_end || (rx_state == RX_START && rx_mid)) ? '0 : rx_cnt + 1'b1;
            case (rx_state)
                RX_IDLE: if (!rx_s) begin
                    rx_state <= RX_START;
                    rx_div   <= div;
                end
                RX_START: if (rx_mid) begin
                    rx_state <= rx_s ? RX_IDLE : RX_DATA;
                    rx_bit   <= '0;
                end
                RX_DATA: if (rx_end) begin
                    rx_shift <= {rx_s, rx_shift[7:1]};
                    rx_bit   <= rx_bit + 1'b1;
                    rx_state <= (rx_bit == 3'd7) ? RX_STOP : RX_DATA;
                end
                RX_STOP: if (rx_end) rx_state <= rx_s ? RX_IDLE : RX_WAIT;
                RX_WAIT: if (rx_s) rx_state <= RX_IDLE;
                default: rx_state <= RX_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_uart_fifo.sv
// tb_wb_uart_fifo: directed and randomized checks of the Wishbone UART against a queue-based model
module tb_wb_uart_fifo;
    localparam int D = 10;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [3:0] wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic [31:0] wb_dat_o;
    logic [3:0] wb_sel_i = '0;
    logic wb_we_i = 1'b0;
    logic wb_stb_i = 1'b0;
    logic wb_cyc_i = 1'b0;
    logic wb_ack_o;
    logic uart_rx = 1'b1;
    logic uart_tx;
    logic irq_o;
    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];

    wb_uart_fifo dut (
        .clock(clock), .reset(reset), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
        .wb_ack_o(wb_ack_o), .uart_rx(uart_rx), .uart_tx(uart_tx), .irq_o(irq_o)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wb_cycle(input logic [3:0] adr, input logic we, input logic [31:0] dat, output logic [31:0] rdat);
        logic got;
        got = 1'b0;
        rdat = '0;
        @(negedge clock);
        wb_adr_i = adr; wb_we_i = we; wb_dat_i = dat; wb_sel_i = 4'hF; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clock); #1;
            if (wb_ack_o) begin
                got = 1'b1;
                rdat = wb_dat_o;
            end
        end
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
        check("wb_ack", 32'(got), 32'd1);
    endtask

    task automatic wb_write(input logic [3:0] adr, input logic [31:0] dat);
        logic [31:0] dummy;
        wb_cycle(adr, 1'b1, dat, dummy);
    endtask

    task automatic wb_read(input logic [3:0] adr, output logic [31:0] dat);
        wb_cycle(adr, 1'b0, 32'd0, dat);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        @(negedge clock);
        for (int k = 0; k < 10; k++) begin
            uart_rx = bits[k];
            repeat (D) @(negedge clock);
        end
        uart_rx = 1'b1;
    endtask

    task automatic tx_capture(input int nframes);
        int bad;
        int k;
        logic seen;
        logic [9:0] fr;
        logic [7:0] b;
        logic e;
        bad = 0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clock); #1;
            seen = (uart_tx == 1'b0);
        end
        check("tx_start_seen", 32'(seen), 32'd1);
        for (int f = 0; f < nframes; f++) begin
            fr = '0;
            b = tx_q.pop_front();
            for (int c = 0; c < 10 * D; c++) begin
                if (f != 0 || c != 0) begin
                    @(posedge clock); #1;
                end
                k = c / D;
                if (c % D == D / 2) fr[k] = uart_tx;
                e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
                if (uart_tx !== e) bad++;
            end
            check($sformatf("tx_frame%0d", f), 32'(fr), 32'({1'b1, b, 1'b0}));
        end
        check("tx_wave_cycles_wrong", 32'(bad), 32'd0);
    endtask

    initial begin
        logic [31:0] r;
        logic [7:0] b;
        int zeros;
        logic ovr;
        // 1: reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_ack", 32'(wb_ack_o), 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        check("rst_tx", 32'(uart_tx), 32'd1);
        check("rst_irq", 32'(irq_o), 32'd0);
        wb_read(4'h8, r);
        check("rst_div", r, 32'd1041);
        wb_read(4'h4, r);
        check("rst_stat", r, 32'h04);
        zeros = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (uart_tx !== 1'b1) zeros++;
        end
        check("rst_tx_idle", 32'(zeros), 32'd0);

        // 2: two back-to-back frames at DIV=10
        wb_write(4'h8, D);
        wb_read(4'h8, r);
        check("div10", r, 32'd10);
        tx_q.push_back(8'h55);
        tx_q.push_back(8'hA3);
        fork
            begin
                wb_write(4'h0, 32'h55);
                wb_write(4'h0, 32'hA3);
            end
            tx_capture(2);
        join
        repeat (3) @(posedge clock);
        wb_read(4'h4, r);
        check("tx_idle_after", r, 32'h04);

        // randomized transmit burst
        for (int i = 0; i < 3; i++) tx_q.push_back(8'($urandom));
        fork
            begin
                logic [7:0] t [3];
                for (int i = 0; i < 3; i++) t[i] = tx_q[i];
                for (int i = 0; i < 3; i++) wb_write(4'h0, 32'(t[i]) | 32'hFFFF_FF00);
            end
            tx_capture(3);
        join
        repeat (3) @(posedge clock);

        // 3: receive one byte with rx irq enabled
        wb_write(4'hC, 32'h1);
        send_rx(8'h3C, 1'b1);
        repeat (4) @(negedge clock);
        check("rx_irq_set", 32'(irq_o), 32'd1);
        wb_read(4'h0, r);
        check("rx_data", r, 32'h13C);
        wb_read(4'h0, r);
        check("rx_empty_read", r, 32'h0);
        repeat (3) @(negedge clock);
        check("rx_irq_clear", 32'(irq_o), 32'd0);

        // 4: overflow the RX FIFO with random bytes
        ovr = 1'b0;
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom);
            if (rx_q.size() < 16) rx_q.push_back(b);
            else ovr = 1'b1;
            send_rx(b, 1'b1);
        end
        repeat (4) @(negedge clock);
        wb_read(4'h4, r);
        check("ovr_stat", r, {28'd0, ovr, 3'b101});
        check("ovr_irq", 32'(irq_o), 32'd1);
        while (rx_q.size() > 0) begin
            b = rx_q.pop_front();
            wb_read(4'h0, r);
            check("ovr_readback", r, {23'd0, 1'b1, b});
        end
        wb_read(4'h0, r);
        check("ovr_drained", r, 32'h0);
        wb_read(4'h4, r);
        check("ovr_stat_drained", r, 32'h0C);
        wb_write(4'h4, 32'h8);
        wb_read(4'h4, r);
        check("ovr_cleared", r, 32'h04);

        // 5: framing error and a start-bit glitch
        send_rx(8'($urandom), 1'b0);
        repeat (4) @(negedge clock);
        wb_read(4'h4, r);
        check("ferr_stat", r, 32'h14);
        wb_read(4'h0, r);
        check("ferr_no_push", r, 32'h0);
        wb_write(4'h4, 32'h10);
        wb_read(4'h4, r);
        check("ferr_cleared", r, 32'h04);
        @(negedge clock);
        uart_rx = 1'b0;
        repeat (2) @(negedge clock);
        uart_rx = 1'b1;
        repeat (30) @(negedge clock);
        wb_read(4'h4, r);
        check("glitch_stat", r, 32'h04);
        wb_read(4'h0, r);
        check("glitch_no_data", r, 32'h0);

        // control register width and tx-empty interrupt
        wb_write(4'hC, 32'hFFFF_FFFE);
        wb_read(4'hC, r);
        check("ctrl_mask", r, 32'h2);
        repeat (2) @(negedge clock);
        check("tx_empty_irq", 32'(irq_o), 32'd1);
        wb_write(4'hC, 32'h0);

        // 6: reset in the middle of a data bit
        wb_write(4'h0, 32'h00);
        repeat (25) @(negedge clock);
        check("tx_mid_data_low", 32'(uart_tx), 32'd0);
        reset = 1'b1;
        @(posedge clock); #1;
        check("tx_reset_high", 32'(uart_tx), 32'd1);
        @(negedge clock);
        reset = 1'b0;
        wb_read(4'h4, r);
        check("post_reset_stat", r, 32'h04);
        wb_read(4'h8, r);
        check("post_reset_div", r, 32'd1041);
        wb_write(4'h8, 32'd1);
        wb_read(4'h8, r);
        check("div_min_clamp", r, 32'd4);
        wb_write(4'h8, 32'd5);
        wb_read(4'h8, r);
        check("div_five", r, 32'd5);
        zeros = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clock); #1;
            if (uart_tx !== 1'b1) zeros++;
        end
        check("post_reset_tx_idle", 32'(zeros), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
